uart_text_writer: RTL and testbench
===================================

Name: uart_text_writer

Overview:
- Sits directly downstream of the UART receiver. Consumes each received byte (one-cycle valid strobe plus byte) and turns it into character-buffer writes for the VGA text renderer.
- Keeps the cursor position, interprets a small set of control codes, and clears lines and the screen by streaming space characters into the buffer.
- The character buffer itself is an external dual-port RAM. This block drives only its write port.

Parameters:
- COLS, 80, characters per row.
- ROWS, 30, rows per screen.
- ADDR_W, 12, character-buffer address width. Must satisfy 2^ADDR_W >= COLS*ROWS.
- COL_W, 7, cursor column width. Must satisfy 2^COL_W >= COLS.
- ROW_W, 5, cursor row width. Must satisfy 2^ROW_W >= ROWS.

Ports:
- i_Clock  in  1  system clock; all logic on the rising edge.
- i_Rst_n  in  1  synchronous, active-low reset.
- i_RX_DV  in  1  one-cycle strobe: i_RX_Byte is valid this cycle.
- i_RX_Byte  in  8  received byte.
- o_Wr_En  out  1  character-buffer write enable, one write per high cycle.
- o_Wr_Addr  out  ADDR_W  write address = row*COLS + col.
- o_Wr_Data  out  8  character code to write.
- o_Cursor_Col  out  COL_W  current cursor column.
- o_Cursor_Row  out  ROW_W  current cursor row.
- o_Busy  out  1  high while a line or screen clear is in progress.
- o_Overrun  out  1  one-cycle pulse: a byte was dropped because o_Busy was high.

Behaviour:
- Clock and reset:
  - One clock. Reset is synchronous and active-low.
  - While i_Rst_n=0: o_Wr_En=0, o_Wr_Addr=0, o_Wr_Data=0, cursor (0,0), o_Overrun=0, o_Busy=1, state = CLR_SCREEN with the clear counter at 0.
  - The first cycle after reset release writes address 0.
- States:
  - IDLE: o_Busy=0.
  - CLR_LINE
  - CLR_SCREEN
- IDLE, i_RX_DV=1: all outputs are registered; the effect appears on the next edge (latency 1 cycle from DV to o_Wr_En).
  - Printable byte, 0x20..0x7E:
    - o_Wr_En=1 for one cycle, o_Wr_Addr = current row*COLS+col, o_Wr_Data = byte.
    - Then col+1.
    - If col was COLS-1: col<=0 and perform a row advance.
  - 0x0D (CR): col<=0. No write.
  - 0x0A (LF): col<=0 and perform a row advance. No write.
  - 0x08 (BS):
    - If col>0: col<=col-1, and write 0x20 at the new position (row*COLS+col-1).
    - If col=0: no movement, no write.
  - 0x0C (FF): cursor<=(0,0), enter CLR_SCREEN.
  - Any other byte: ignored, nothing changes.
- Row advance:
  - row<=row+1, or 0 if row was ROWS-1 (wrap, no scrolling).
  - Enter CLR_LINE for the new row.
- CLR_LINE:
  - Writes 0x20 to new_row*COLS+k for k=0..COLS-1, one per cycle, consecutive cycles, o_Wr_En held high.
  - Returns to IDLE after the write at k=COLS-1. o_Busy drops the cycle after that last write.
  - The cursor already shows the new row, col 0, throughout.
- CLR_SCREEN:
  - Writes 0x20 to addresses 0..COLS*ROWS-1, one per cycle.
  - Then IDLE with cursor (0,0).
- A printable byte at col COLS-1 produces its character write first, then the CLR_LINE writes starting the next cycle. No idle gap between them.
- i_RX_DV=1 while o_Busy=1 (either clear state):
  - The byte is dropped. Cursor and clear progress are unaffected.
  - o_Overrun=1 on the next cycle for exactly one cycle.
- o_Wr_En is never high outside the cases above.
- o_Wr_Addr and o_Wr_Data hold their last values when o_Wr_En=0.
- Reset asserted mid-clear or mid-operation: the operation is abandoned; on release the full CLR_SCREEN restarts from address 0.
- Arithmetic:
  - Address computed at ADDR_W bits. Never exceeds COLS*ROWS-1.
  - Column and row counters never reach COLS or ROWS.

Test Plan:
- Reset pulse, hold i_RX_DV=0:
  - Expect 2400 consecutive writes of 0x20 to addresses 0..2399.
  - Then o_Busy=0, cursor (0,0), no further writes.
- After the clear, send 'H'(0x48) then 'i'(0x69):
  - Writes (0,0x48) then (1,0x69), each one cycle after its DV.
  - Cursor ends at (col 2, row 0).
- Send 81 printable 'A' bytes from (0,0):
  - 80 writes at addresses 0..79.
  - CLR_LINE writes 0x20 to 80..159, starting the cycle after the address-79 write.
  - Then 'A' at 80. Cursor ends at (1,1).
- Cursor at (0,29), send LF:
  - Row wraps to 0 and 0x20 is written to addresses 0..79.
  - Send a byte during that clear: it is dropped, o_Overrun pulses exactly once, the cursor is unchanged.
- BS handling:
  - Cursor at (5,3), send 0x08: write 0x20 to address 244, cursor (4,3).
  - Cursor at (0,3), send 0x08: no write, no move.
  - Send 0x0D, then 0x07: only col is affected (col<=0), and 0x07 produces no effect.
- Send 0x0C mid-screen, then assert i_Rst_n=0 after 100 clear writes:
  - After release, the clear restarts at address 0 and runs the full 2400 writes.

Source files
------------

// File: rtl/uart_text_writer.sv
// uart_text_writer: turns received UART bytes into character-buffer writes,
// tracking the cursor and clearing lines/screen with streamed spaces.
module uart_text_writer #(
  parameter int COLS   = 80,
  parameter int ROWS   = 30,
  parameter int ADDR_W = 12,
  parameter int COL_W  = 7,
  parameter int ROW_W  = 5
) (
  input  logic              i_Clock,
  input  logic              i_Rst_n,
  input  logic              i_RX_DV,
  input  logic [7:0]        i_RX_Byte,
  output logic              o_Wr_En,
  output logic [ADDR_W-1:0] o_Wr_Addr,
  output logic [7:0]        o_Wr_Data,
  output logic [COL_W-1:0]  o_Cursor_Col,
  output logic [ROW_W-1:0]  o_Cursor_Row,
  output logic              o_Busy,
  output logic              o_Overrun
);
  typedef enum logic [1:0] {IDLE, CLR_LINE, CLR_SCREEN} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, addr_q, addr_d, row_base;
  logic [COL_W-1:0] col_q, col_d, col_m1;
  logic [ROW_W-1:0] row_q, row_d;
  logic [7:0] data_q, data_d;
  logic we_q, we_d, busy_q, busy_d, ovr_q, ovr_d, adv, prt;
  assign row_base = ADDR_W'(row_q) * ADDR_W'(COLS);
  assign col_m1 = col_q - COL_W'(1);
  assign prt = i_RX_Byte >= 8'h20 && i_RX_Byte <= 8'h7E;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    col_d = col_q;
    row_d = row_q;
    we_d = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    adv = 1'b0;
    ovr_d = i_RX_DV & busy_q;
    case (state_q)
      CLR_SCREEN: begin
        we_d = 1'b1;
        addr_d = cnt_q;
        data_d = 8'h20;
        cnt_d = cnt_q + ADDR_W'(1);
        state_d = cnt_q == ADDR_W'(COLS*ROWS-1) ? IDLE : CLR_SCREEN;
      end
      CLR_LINE: begin
        we_d = 1'b1;
        addr_d = row_base + cnt_q;
        data_d = 8'h20;
        cnt_d = cnt_q + ADDR_W'(1);
        state_d = cnt_q == ADDR_W'(COLS-1) ? IDLE : CLR_LINE;
      end
      default: begin
        // busy_q stays high through the final clear write, so bytes are only taken once it drops
        if (i_RX_DV && !busy_q) begin
          if (prt) begin
            we_d = 1'b1;
            addr_d = row_base + ADDR_W'(col_q);
            data_d = i_RX_Byte;
            adv = col_q == COL_W'(COLS-1);
            col_d = adv ? '0 : col_q + COL_W'(1);
          end else if (i_RX_Byte == 8'h0D) begin
            col_d = '0;
          end else if (i_RX_Byte == 8'h0A) begin
            col_d = '0;
            adv = 1'b1;
          end else if (i_RX_Byte == 8'h08 && col_q != '0) begin
            col_d = col_m1;
            we_d = 1'b1;
            addr_d = row_base + ADDR_W'(col_m1);
            data_d = 8'h20;
          end else if (i_RX_Byte == 8'h0C) begin
            col_d = '0;
            row_d = '0;
            cnt_d = '0;
            state_d = CLR_SCREEN;
          end
        end
      end
    endcase
    if (adv) begin
      row_d = row_q == ROW_W'(ROWS-1) ? '0 : row_q + ROW_W'(1);
      cnt_d = '0;
      state_d = CLR_LINE;
    end
    busy_d = state_q != IDLE || state_d != IDLE;
  end
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      state_q <= CLR_SCREEN;
      cnt_q <= '0;
      col_q <= '0;
      row_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      busy_q <= 1'b1;
      ovr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      col_q <= col_d;
      row_q <= row_d;
      we_q <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
      busy_q <= busy_d;
      ovr_q <= ovr_d;
    end
  end
  assign o_Wr_En = we_q;
  assign o_Wr_Addr = addr_q;
  assign o_Wr_Data = data_q;
  assign o_Cursor_Col = col_q;
  assign o_Cursor_Row = row_q;
  assign o_Busy = busy_q;
  assign o_Overrun = ovr_q;
endmodule

// File: tb/tb_uart_text_writer.sv
// tb_uart_text_writer: directed checks of uart_text_writer against hand-computed writes and cursor positions.
module tb_uart_text_writer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dv = 1'b0;
  logic [7:0] rx = 8'h00;
  logic we, busy, ovr;
  logic [11:0] addr;
  logic [7:0] data;
  logic [6:0] col;
  logic [4:0] row;
  int vectors = 0;
  int errors = 0;
  always #5 clk = ~clk;
  uart_text_writer dut (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_RX_DV(dv), .i_RX_Byte(rx),
    .o_Wr_En(we), .o_Wr_Addr(addr), .o_Wr_Data(data),
    .o_Cursor_Col(col), .o_Cursor_Row(row), .o_Busy(busy), .o_Overrun(ovr)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    dv = 1'b1;
    rx = b;
    @(negedge clk);
    dv = 1'b0;
  endtask
  task automatic wr(input string tag, input int a, input int d);
    chk({tag, "_we"}, 32'(we), 1);
    chk({tag, "_addr"}, 32'(addr), a);
    chk({tag, "_data"}, 32'(data), d);
  endtask
  task automatic cur(input string tag, input int c, input int r);
    chk({tag, "_col"}, 32'(col), c);
    chk({tag, "_row"}, 32'(row), r);
  endtask
  task automatic nowr(input string tag);
    chk({tag, "_we"}, 32'(we), 0);
  endtask
  task automatic clr(input string tag, input int start, input int n, input int drop, input int c, input int r);
    for (int k = 0; k < n; k++) begin
      if (k == drop) begin
        dv = 1'b1;
        rx = 8'h5A;
      end
      @(negedge clk);
      dv = 1'b0;
      wr(tag, start + k, 8'h20);
      chk({tag, "_busy"}, 32'(busy), 1);
      chk({tag, "_ovr"}, 32'(ovr), k == drop ? 1 : 0);
      if (k == drop) cur({tag, "_drop"}, c, r);
    end
  endtask
  task automatic idle(input string tag, input int c, input int r);
    @(negedge clk);
    chk({tag, "_busy"}, 32'(busy), 0);
    nowr(tag);
    chk({tag, "_ovr"}, 32'(ovr), 0);
    cur(tag, c, r);
  endtask
  task automatic rst_chk(input string tag);
    nowr(tag);
    chk({tag, "_addr"}, 32'(addr), 0);
    chk({tag, "_data"}, 32'(data), 0);
    chk({tag, "_busy"}, 32'(busy), 1);
    chk({tag, "_ovr"}, 32'(ovr), 0);
    cur(tag, 0, 0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    rst_chk("reset");
    rst_n = 1'b1;
    clr("boot", 0, 2400, -1, 0, 0);
    idle("boot_done", 0, 0);
    idle("boot_quiet", 0, 0);
    send(8'h48);
    wr("H", 0, 8'h48);
    send(8'h69);
    wr("i", 1, 8'h69);
    cur("Hi", 2, 0);
    send(8'h0D);
    nowr("cr0");
    cur("cr0", 0, 0);
    for (int i = 0; i < 80; i++) begin
      send(8'h41);
      wr("A", i, 8'h41);
    end
    cur("wrap", 0, 1);
    chk("wrap_busy", 32'(busy), 1);
    clr("wrapclr", 80, 80, -1, 0, 1);
    idle("wrap_done", 0, 1);
    send(8'h41);
    wr("A81", 80, 8'h41);
    cur("A81", 1, 1);
    send(8'h0D);
    for (int r = 2; r < 30; r++) begin
      send(8'h0A);
      nowr("lf");
      cur("lf", 0, r);
      clr("lfclr", r * 80, 80, -1, 0, r);
      idle("lf_done", 0, r);
    end
    send(8'h0A);
    nowr("lfwrap");
    cur("lfwrap", 0, 0);
    clr("lfwrapclr", 0, 80, 10, 0, 0);
    idle("lfwrap_done", 0, 0);
    for (int r = 1; r <= 3; r++) begin
      send(8'h0A);
      clr("lf3", r * 80, 80, -1, 0, r);
      idle("lf3_done", 0, r);
    end
    for (int i = 0; i < 5; i++) begin
      send(8'h78);
      wr("x", 240 + i, 8'h78);
    end
    cur("x5", 5, 3);
    send(8'h08);
    wr("bs", 244, 8'h20);
    cur("bs", 4, 3);
    send(8'h07);
    nowr("bel");
    cur("bel", 4, 3);
    send(8'h0D);
    nowr("cr");
    cur("cr", 0, 3);
    send(8'h08);
    nowr("bs0");
    cur("bs0", 0, 3);
    idle("bs0_quiet", 0, 3);
    send(8'h71);
    wr("q", 240, 8'h71);
    send(8'h0C);
    nowr("ff");
    cur("ff", 0, 0);
    chk("ff_busy", 32'(busy), 1);
    clr("ffclr", 0, 100, -1, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_chk("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    clr("reboot", 0, 2400, -1, 0, 0);
    idle("reboot_done", 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
